// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR filter datapath.
// Sample format and the legal decimation range used by the output stage.
package fir_pkg;
  localparam int SAMPLE_W  = 16;
  localparam int DECIM_MIN = 1;
  localparam int DECIM_MAX = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic bit decim_ok(input int d);
    return (d >= DECIM_MIN) && (d <= DECIM_MAX);
  endfunction
endpackage

// File: rtl/fir_decimating_output_buffer_sample_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// The head is read combinationally from the array, so it is valid in the cycle after a push.
module sample_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fill_q, fill_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign fill_o  = fill_q;
  assign full_o  = (fill_q == FULL_CNT);
  assign empty_o = (fill_q == '0);
endmodule

// File: rtl/fir_decimating_output_buffer.sv
// FIR output stage: keeps every DECIM-th valid sample and buffers it for a stalling consumer.
// Samples arriving while the buffer is full are dropped and latched into a sticky overflow flag.
module fir_decimating_output_buffer
  import fir_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DECIM = 2,
  parameter int DEPTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  input  logic signed [WIDTH-1:0]   in_sample_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic signed [WIDTH-1:0]   out_sample_o,
  output logic [$clog2(DEPTH):0]    fill_o,
  output logic                      overflow_o
);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);

  if (!decim_ok(DECIM)) begin : g_bad_decim
    $error("fir_decimating_output_buffer: DECIM out of range");
  end

  logic [PW-1:0]    phase_q, phase_d;
  logic             overflow_q, overflow_d;
  logic             keep, push, pop, drop;
  logic             full, empty;
  logic [WIDTH-1:0] head;

  always_comb begin
    phase_d    = phase_q;
    keep       = in_valid_i && (phase_q == '0);
    pop        = !empty && out_ready_i;
    push       = keep && (!full || pop);
    drop       = keep && full && !pop;
    overflow_d = overflow_q | drop;
    if (in_valid_i) phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (in_sample_i),
    .dout_o  (head),
    .fill_o  (fill_o),
    .full_o  (full),
    .empty_o (empty)
  );

  // Stale RAM content must never leak out while the buffer is empty.
  assign out_valid_o  = !empty;
  assign out_sample_o = empty ? '0 : head;
  assign overflow_o   = overflow_q;
endmodule

// File: tb/tb_fir_decimating_output_buffer.sv
// Scoreboard bench: three buffer instances (DECIM 2, 1, 3; DEPTH 8) with directed vectors.
module tb_fir_decimating_output_buffer;
  import fir_pkg::*;

  localparam int N = 3;

  logic    clk = 1'b0;
  logic    rst;
  logic    in_valid  [N];
  sample_t in_sample [N];
  logic    out_valid [N];
  logic    out_ready [N];
  sample_t out_sample[N];
  logic [3:0] fill   [N];
  logic    overflow  [N];

  sample_t exp_q [N][$];
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    fir_decimating_output_buffer #(
      .WIDTH (16),
      .DECIM ((g == 0) ? 2 : (g == 1) ? 1 : 3),
      .DEPTH (8)
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .in_valid_i   (in_valid[g]),
      .in_sample_i  (in_sample[g]),
      .out_valid_o  (out_valid[g]),
      .out_ready_i  (out_ready[g]),
      .out_sample_o (out_sample[g]),
      .fill_o       (fill[g]),
      .overflow_o   (overflow[g])
    );
  end

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int i, input string name);
    for (int c = 0; c < 30 && fill[i] != 0; c++) tick();
    check(name, int'(fill[i]), 0);
  endtask

  // Monitor: every accepted head must match the oldest expected sample.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("unexpected_out%0d", i), 1, 0);
          end else begin
            automatic sample_t e = exp_q[i].pop_front();
            check($sformatf("sample_out%0d", i), int'(out_sample[i]), int'(e));
          end
        end else if (!out_valid[i]) begin
          check($sformatf("empty_zero%0d", i), int'(out_sample[i]), 0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0; in_sample[i] = '0; out_ready[i] = 1'b0;
    end
    tick(); tick();
    for (int i = 0; i < N; i++) begin
      check("rst_fill", int'(fill[i]), 0);
      check("rst_valid", int'(out_valid[i]), 0);
      check("rst_sample", int'(out_sample[i]), 0);
      check("rst_ovf", int'(overflow[i]), 0);
    end
    rst = 1'b0;

    // DECIM=2, always ready: 1..6 -> 1,3,5 one cycle after input
    out_ready[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      in_valid[0] = 1'b1; in_sample[0] = sample_t'(k);
      if (k % 2 == 1) exp_q[0].push_back(sample_t'(k));
      tick();
      check("t1_latency_valid", int'(out_valid[0]), k % 2);
      if (k % 2 == 1) check("t1_latency_sample", int'(out_sample[0]), k);
      check("t1_fill_le1", int'(fill[0] <= 1), 1);
    end
    in_valid[0] = 1'b0;
    tick();

    // DECIM=1, stalled consumer: 10..19, overflow on the 9th
    out_ready[1] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      in_valid[1] = 1'b1; in_sample[1] = sample_t'(10 + j);
      if (j < 8) exp_q[1].push_back(sample_t'(10 + j));
      tick();
      check("t2_fill", int'(fill[1]), (j < 8) ? j + 1 : 8);
      check("t2_ovf", int'(overflow[1]), (j >= 8) ? 1 : 0);
    end
    in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    drain(1, "t2_drain_fill");
    check("t2_ovf_sticky", int'(overflow[1]), 1);

    // Full FIFO with simultaneous kept sample and pop
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < N; i++) exp_q[i].delete();
    check("t3_ovf_cleared", int'(overflow[1]), 0);
    out_ready[1] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      in_valid[1] = 1'b1; in_sample[1] = sample_t'(20 + j);
      exp_q[1].push_back(sample_t'(20 + j));
      tick();
    end
    check("t3_full_fill", int'(fill[1]), 8);
    in_sample[1] = 16'sd28; out_ready[1] = 1'b1;
    exp_q[1].push_back(16'sd28);
    tick();
    check("t3_pushpop_fill", int'(fill[1]), 8);
    check("t3_pushpop_ovf", int'(overflow[1]), 0);
    in_valid[1] = 1'b0;
    drain(1, "t3_drain_fill");

    // Extreme values, bit-exact
    out_ready[1] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      automatic sample_t v = (j == 0) ? -16'sd32768 : (j == 1) ? -16'sd1 : 16'sd32767;
      in_valid[1] = 1'b1; in_sample[1] = v;
      exp_q[1].push_back(v);
      tick();
      check("t4_bitexact", int'(out_sample[1]), int'(v));
    end
    in_valid[1] = 1'b0;
    drain(1, "t4_drain_fill");

    // DECIM=3 with idle gaps: 7,-,8,-,9,10 -> 7,10
    out_ready[2] = 1'b1;
    for (int s = 0; s < 6; s++) begin
      automatic int v = (s == 0) ? 7 : (s == 2) ? 8 : (s == 4) ? 9 : (s == 5) ? 10 : 0;
      in_valid[2] = (v != 0); in_sample[2] = sample_t'(v);
      if (v == 7 || v == 10) exp_q[2].push_back(sample_t'(v));
      tick();
    end
    in_valid[2] = 1'b0;
    drain(2, "t5_drain_fill");

    // Reset with fill=5 and overflow set
    out_ready[1] = 1'b0;
    for (int j = 0; j < 9; j++) begin
      in_valid[1] = 1'b1; in_sample[1] = sample_t'(30 + j);
      if (j < 8) exp_q[1].push_back(sample_t'(30 + j));
      tick();
    end
    in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    tick(); tick(); tick();
    out_ready[1] = 1'b0;
    check("t6_pre_fill", int'(fill[1]), 5);
    check("t6_pre_ovf", int'(overflow[1]), 1);
    rst = 1'b1; tick();
    for (int i = 0; i < N; i++) exp_q[i].delete();
    check("t6_rst_fill", int'(fill[1]), 0);
    check("t6_rst_valid", int'(out_valid[1]), 0);
    check("t6_rst_sample", int'(out_sample[1]), 0);
    check("t6_rst_ovf", int'(overflow[1]), 0);
    rst = 1'b0;
    in_valid[1] = 1'b1; in_sample[1] = 16'sd99;
    exp_q[1].push_back(16'sd99);
    tick();
    check("t6_first_kept_valid", int'(out_valid[1]), 1);
    check("t6_first_kept_sample", int'(out_sample[1]), 99);
    in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    drain(1, "t6_drain_fill");
    tick();

    for (int i = 0; i < N; i++) check("queue_empty", exp_q[i].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/fir_decimating_output_buffer.md
# fir_decimating_output_buffer

Downstream stage of the FIR filter: consumes one signed 16-bit filter result per valid cycle, keeps every DECIM-th sample, and buffers kept samples in a small synchronous FIFO. Results go to the consumer (DAC interface or capture logic) over a valid/ready handshake. Absorbs consumer stalls without back-pressuring the filter. Loss on overflow is flagged, never silent.

## Interface
- `WIDTH`, 16: sample width, signed two's complement.
- `DECIM`, 2: decimation factor, legal range 1..16; 1 keeps every sample.
- `DEPTH`, 8: FIFO depth in samples, power of two, 2..64.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_sample` carries a filter result this cycle.
- `in_sample` input WIDTH: signed filter output.
- `out_valid` output 1: FIFO non-empty; `out_sample` holds the head.
- `out_ready` input 1: consumer accepts the head this cycle.
- `out_sample` output WIDTH: signed head sample; 0 when empty.
- `fill` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` output 1: sticky; a kept sample was dropped because the FIFO was full.

## Operation
- Phase counter `phase`, range 0..DECIM-1. It advances on every `in_valid` cycle and wraps from DECIM-1 to 0.
- A sample is kept when `in_valid && phase==0`. The first valid sample after reset is always kept.
- Push = kept && (!full || pop). Pop = `out_valid && out_ready`.
- Full with a kept sample and no pop: the sample is dropped, `overflow` sets, and phase still advances.
- Full with a kept sample and a pop in the same cycle: both happen; `fill` is unchanged; no overflow.
- Empty with a push: no pass-through. The sample becomes visible the next cycle.
- `out_ready` while `out_valid==0` has no effect.
- `overflow` clears only on `rst`.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty come from `fill` (DEPTH/0).
- Data passes unmodified: no rounding, no saturation, bit-exact.

## Timing
- Reset values: `out_valid`=0, `out_sample`=0, `fill`=0, `overflow`=0, `phase`=0, pointers 0. FIFO RAM contents are don't-care.
- `rst` mid-stream discards all buffered samples. The first valid after reset release is kept.
- Latency: kept sample on `in_valid` in cycle t gives `out_valid`=1 with that sample in cycle t+1, if the FIFO was empty.
- `out_sample` is stable while `out_valid && !out_ready`.
- `out_valid` never drops without a pop or `rst`.
- Throughput: one push and one pop per cycle sustained.
- `fill` and `overflow` update in the cycle after the causing event, as registered outputs.

## Structure
- Shared package `fir_pkg`: `SAMPLE_W`=16, `sample_t` (signed [SAMPLE_W-1:0]), and a decimation-range check constant.
- Sub-module `sample_fifo`: parameterised WIDTH/DEPTH synchronous FIFO.
  - Ports: push/pop/din/dout/fill/full/empty.
  - Registered pointers and count; array memory with combinational read of the head.
- Top level holds:
  - the phase counter;
  - keep/push/drop logic;
  - the overflow flag;
  - zero-masking of `out_sample` when empty.

## Test plan
- Reset, then DECIM=2, `out_ready`=1, `in_valid`=1 with samples 1,2,3,4,5,6 on consecutive cycles -> outputs 1,3,5. Each appears one cycle after input; `fill` ≤1.
- DECIM=1, DEPTH=8, `out_ready`=0, ten consecutive samples 10..19 -> `fill`=8, `overflow`=1 after the 9th. Then `out_ready`=1 drains exactly 10..17 in order and `fill` returns to 0.
- Full FIFO, simultaneous kept sample and pop -> `fill` stays 8, `overflow` stays 0, and the new sample appears last on drain.
- Negative values -32768, -1, 32767 with DECIM=1 -> bit-exact on `out_sample`, no sign alteration.
- `in_valid` gaps with DECIM=3 (valid, idle, valid, idle, valid, valid) on samples 7,8,9,10 -> only 7 and 10 output, since the phase counts valid cycles only.
- Assert `rst` with `fill`=5 and `overflow`=1 -> next cycle `fill`=0, `out_valid`=0, `out_sample`=0, `overflow`=0. The first post-reset sample is kept.
